// File: rtl/vga_scan_if.sv
// Scan-controller bundle: snapshot handshake plus the sync/scan outputs that
// feed the print/line_map/bit_map datapath.
interface vga_scan_if;
  logic        snap_req;
  logic        snap_ack;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic [10:0] addr_row;
  logic [10:0] addr_column;
  logic        frame_tick;
  logic        pix_en;

  modport master (
    input  snap_req,
    output snap_ack, hsync, vsync, valid, addr_row, addr_column, frame_tick, pix_en
  );

  modport slave (
    output snap_req,
    input  snap_ack, hsync, vsync, valid, addr_row, addr_column, frame_tick, pix_en
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA timing/scan controller with a vblank-aligned snapshot handshake.
// Optional VGA_PIPE_EN: delays sync/valid/addr by 2 clks to match the colour lookups.
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic          clk,
  input  logic          reset,
  vga_scan_if.master    bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [10:0] row;
    logic [10:0] col;
  } disp_t;

  localparam disp_t DISP_RST = '{hsync: 1'b1, vsync: 1'b1, valid: 1'b0, row: '0, col: '0};

  typedef enum logic [1:0] {IDLE, PEND, GRANT} snap_st_t;

  logic [DW-1:0] div;
  logic [10:0]   hcnt, vcnt, hcnt_nxt, vcnt_nxt;
  logic          tick, h_wrap;
  logic          pix_en_q, ft_q;
  disp_t         disp_nxt, disp_q, disp_o;
  snap_st_t      st_q, st_d;
  logic          ack;

  // Counters advance on the same edge that raises pix_en, so every output
  // registered from the *_nxt values lines up with hcnt/vcnt in that clk.
  always_comb begin
    tick     = (div == DW'(CLK_DIV - 1));
    h_wrap   = (hcnt == 11'(H_TOTAL - 1));
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    if (tick) begin
      hcnt_nxt = h_wrap ? 11'd0 : hcnt + 11'd1;
      if (h_wrap)
        vcnt_nxt = (vcnt == 11'(V_TOTAL - 1)) ? 11'd0 : vcnt + 11'd1;
    end
    disp_nxt.hsync = !((hcnt_nxt >= 11'(H_ACTIVE + H_FP)) &&
                       (hcnt_nxt <  11'(H_ACTIVE + H_FP + H_SYNC)));
    disp_nxt.vsync = !((vcnt_nxt >= 11'(V_ACTIVE + V_FP)) &&
                       (vcnt_nxt <  11'(V_ACTIVE + V_FP + V_SYNC)));
    disp_nxt.valid = (hcnt_nxt < 11'(H_ACTIVE)) && (vcnt_nxt < 11'(V_ACTIVE));
    disp_nxt.row   = vcnt_nxt;
    disp_nxt.col   = hcnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div      <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
      pix_en_q <= 1'b0;
      ft_q     <= 1'b0;
      disp_q   <= DISP_RST;
    end else begin
      div      <= tick ? '0 : div + DW'(1);
      hcnt     <= hcnt_nxt;
      vcnt     <= vcnt_nxt;
      pix_en_q <= tick;
      ft_q     <= tick && h_wrap && (vcnt == 11'(V_ACTIVE - 1));
      disp_q   <= disp_nxt;
    end
  end

`ifdef VGA_PIPE_EN
  disp_t disp_pipe [2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_pipe[0] <= DISP_RST;
      disp_pipe[1] <= DISP_RST;
    end else begin
      disp_pipe[0] <= disp_q;
      disp_pipe[1] <= disp_pipe[0];
    end
  end

  assign disp_o = disp_pipe[1];
`else
  assign disp_o = disp_q;
`endif

  // A request seen in the frame_tick clk itself waits a whole frame: the
  // grant only follows a frame_tick observed while already pending.
  always_ff @(posedge clk) begin
    if (!reset) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    ack  = 1'b0;
    case (st_q)
      IDLE:    if (bus.snap_req) st_d = PEND;
      PEND:    if (ft_q)         st_d = GRANT;
      GRANT: begin
        ack  = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign bus.snap_ack    = ack;
  assign bus.hsync       = disp_o.hsync;
  assign bus.vsync       = disp_o.vsync;
  assign bus.valid       = disp_o.valid;
  assign bus.addr_row    = disp_o.row;
  assign bus.addr_column = disp_o.col;
  assign bus.frame_tick  = ft_q;
  assign bus.pix_en      = pix_en_q;
endmodule
